// File: rtl/sump_cmd_decoder.sv
// Assembles SUMP short (1-byte) and long (opcode + 4 LE argument bytes) commands into {config_data, opcode}.
// execute is registered, one cycle after the final byte; every rx_valid is accepted, with no backpressure.
module sump_cmd_decoder #(
    parameter int TIMEOUT = 50_000,
    parameter int CNTW    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [39:0] cmd,
    output logic        execute,
    output logic        in_cmd,
    output logic        timeout_err
);

    typedef enum logic {IDLE = 1'b0, ARG = 1'b1} state_t;

    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

    state_t            state_q, state_d;
    logic [39:0]       cmd_q, cmd_d;
    logic              execute_q, execute_d;
    logic              in_cmd_q, in_cmd_d;
    logic              timeout_err_q, timeout_err_d;
    logic [31:0]       shadow_q, shadow_d;
    logic [1:0]        idx_q, idx_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;

    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        execute_d     = 1'b0;
        in_cmd_d      = in_cmd_q;
        timeout_err_d = 1'b0;
        shadow_d      = shadow_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;

        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    if (!rx_data[7]) begin
                        cmd_d     = {32'h0, rx_data};
                        execute_d = 1'b1;
                    end else begin
                        shadow_d = {24'h0, rx_data};
                        idx_d    = 2'd0;
                        cnt_d    = '0;
                        state_d  = ARG;
                        in_cmd_d = 1'b1;
                    end
                end
            end
            ARG: begin
                // A byte on the expiry cycle wins over the timeout.
                if (rx_valid) begin
                    cnt_d = '0;
                    idx_d = idx_q + 2'd1;
                    case (idx_q)
                        2'd0:    shadow_d[15:8]  = rx_data;
                        2'd1:    shadow_d[23:16] = rx_data;
                        2'd2:    shadow_d[31:24] = rx_data;
                        default: begin
                            // The last argument byte goes straight into cmd, so the shadow only needs 32 bits.
                            cmd_d     = {rx_data, shadow_q};
                            execute_d = 1'b1;
                            state_d   = IDLE;
                            in_cmd_d  = 1'b0;
                        end
                    endcase
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = IDLE;
                    in_cmd_d      = 1'b0;
                    timeout_err_d = 1'b1;
                    shadow_d      = '0;
                    idx_d         = 2'd0;
                    cnt_d         = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cmd_q         <= '0;
            execute_q     <= 1'b0;
            in_cmd_q      <= 1'b0;
            timeout_err_q <= 1'b0;
            shadow_q      <= '0;
            idx_q         <= 2'd0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            execute_q     <= execute_d;
            in_cmd_q      <= in_cmd_d;
            timeout_err_q <= timeout_err_d;
            shadow_q      <= shadow_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
        end
    end

    assign cmd         = cmd_q;
    assign execute     = execute_q;
    assign in_cmd      = in_cmd_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_sump_cmd_decoder.sv
// Bench for sump_cmd_decoder: per-cycle vectors carry inputs and the outputs expected after that edge.
module tb_sump_cmd_decoder;

    localparam int TO   = 8;
    localparam int CNTW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_data = 8'h0;
    logic        rx_valid = 1'b0;
    logic [39:0] cmd;
    logic        execute;
    logic        in_cmd;
    logic        timeout_err;

    sump_cmd_decoder #(.TIMEOUT(TO), .CNTW(CNTW)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .cmd         (cmd),
        .execute     (execute),
        .in_cmd      (in_cmd),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [7:0]  dat;
        logic        ex;
        logic        te;
        logic        ic;
        logic [39:0] c;
        string       tag;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[$];
    int   n_total = 0;
    int   n_pass  = 0;

    function automatic vec_t mk(input logic vld, input logic [7:0] dat, input logic ex,
                                input logic te, input logic ic, input logic [39:0] c, input string tag);
        vec_t v;
        v.vld = vld; v.dat = dat; v.ex = ex; v.te = te; v.ic = ic; v.c = c; v.tag = tag;
        return v;
    endfunction

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Scoreboard: compare outputs shortly after each edge against the expectation pushed by the driver.
    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            vec_t e;
            e = sb.pop_front();
            chk({e.tag, ".execute"},     {39'h0, execute},     {39'h0, e.ex});
            chk({e.tag, ".timeout_err"}, {39'h0, timeout_err}, {39'h0, e.te});
            chk({e.tag, ".in_cmd"},      {39'h0, in_cmd},      {39'h0, e.ic});
            chk({e.tag, ".cmd"},         cmd,                  e.c);
        end
    end

    task automatic apply(input vec_t v);
        @(negedge clk);
        rx_valid = v.vld;
        rx_data  = v.dat;
        sb.push_back(v);
    endtask

    task automatic idle_n(input int n, input logic ic, input logic [39:0] c, input string tag);
        for (int i = 0; i < n; i++) apply(mk(1'b0, 8'h00, 1'b0, 1'b0, ic, c, tag));
    endtask

    initial begin
        // Reset state, checked while reset is held.
        #12;
        chk("rst.cmd",         cmd,                  40'h0);
        chk("rst.execute",     {39'h0, execute},     40'h0);
        chk("rst.in_cmd",      {39'h0, in_cmd},      40'h0);
        chk("rst.timeout_err", {39'h0, timeout_err}, 40'h0);
        @(negedge clk);
        rst = 1'b1;

        tbl.push_back(mk(1, 8'h01, 1, 0, 0, 40'h00_0000_0001, "short01"));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 40'h00_0000_0001, "hold01"));
        tbl.push_back(mk(1, 8'h80, 0, 0, 1, 40'h00_0000_0001, "long80.op"));
        tbl.push_back(mk(1, 8'h11, 0, 0, 1, 40'h00_0000_0001, "long80.a0"));
        tbl.push_back(mk(1, 8'h22, 0, 0, 1, 40'h00_0000_0001, "long80.a1"));
        tbl.push_back(mk(1, 8'h33, 0, 0, 1, 40'h00_0000_0001, "long80.a2"));
        tbl.push_back(mk(1, 8'h44, 1, 0, 0, 40'h44_3322_1180, "long80.a3"));
        tbl.push_back(mk(1, 8'h02, 1, 0, 0, 40'h00_0000_0002, "b2b.short02"));
        tbl.push_back(mk(1, 8'h82, 0, 0, 1, 40'h00_0000_0002, "b2b.op82"));
        tbl.push_back(mk(1, 8'hAA, 0, 0, 1, 40'h00_0000_0002, "b2b.a0"));
        tbl.push_back(mk(1, 8'hBB, 0, 0, 1, 40'h00_0000_0002, "b2b.a1"));
        tbl.push_back(mk(1, 8'hCC, 0, 0, 1, 40'h00_0000_0002, "b2b.a2"));
        tbl.push_back(mk(1, 8'hDD, 1, 0, 0, 40'hDD_CCBB_AA82, "b2b.a3"));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 40'hDD_CCBB_AA82, "b2b.hold"));
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Timeout: TO idle cycles after an argument byte discard the partial command.
        apply(mk(1, 8'hC0, 0, 0, 1, 40'hDD_CCBB_AA82, "to.op"));
        apply(mk(1, 8'h01, 0, 0, 1, 40'hDD_CCBB_AA82, "to.a0"));
        idle_n(TO - 1, 1'b1, 40'hDD_CCBB_AA82, "to.wait");
        apply(mk(0, 8'h00, 0, 1, 0, 40'hDD_CCBB_AA82, "to.expire"));
        apply(mk(1, 8'h02, 1, 0, 0, 40'h00_0000_0002, "to.next02"));
        apply(mk(0, 8'h00, 0, 0, 0, 40'h00_0000_0002, "to.hold"));

        // Byte arriving exactly on the expiry cycle is accepted.
        apply(mk(1, 8'h85, 0, 0, 1, 40'h00_0000_0002, "edge.op"));
        apply(mk(1, 8'hA1, 0, 0, 1, 40'h00_0000_0002, "edge.a0"));
        idle_n(TO - 1, 1'b1, 40'h00_0000_0002, "edge.gap");
        apply(mk(1, 8'hA2, 0, 0, 1, 40'h00_0000_0002, "edge.a1"));
        apply(mk(1, 8'hA3, 0, 0, 1, 40'h00_0000_0002, "edge.a2"));
        apply(mk(1, 8'hA4, 1, 0, 0, 40'hA4_A3A2_A185, "edge.a3"));
        apply(mk(0, 8'h00, 0, 0, 0, 40'hA4_A3A2_A185, "edge.hold"));

        // Reset in the middle of a long command.
        apply(mk(1, 8'h81, 0, 0, 1, 40'hA4_A3A2_A185, "mid.op"));
        apply(mk(1, 8'h01, 0, 0, 1, 40'hA4_A3A2_A185, "mid.a0"));
        apply(mk(1, 8'h02, 0, 0, 1, 40'hA4_A3A2_A185, "mid.a1"));
        @(negedge clk);
        rx_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("mid.rst.cmd",     cmd,              40'h0);
        chk("mid.rst.in_cmd",  {39'h0, in_cmd},  40'h0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("mid.rst.execute",     {39'h0, execute},     40'h0);
            chk("mid.rst.timeout_err", {39'h0, timeout_err}, 40'h0);
        end
        @(negedge clk);
        rst = 1'b1;
        apply(mk(1, 8'h00, 1, 0, 0, 40'h00_0000_0000, "mid.short00"));
        apply(mk(0, 8'h00, 0, 0, 0, 40'h00_0000_0000, "mid.hold"));

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
